// File: rtl/mips_mc_controller_if.sv
// rtl/mips_mc_controller_if.sv - control bundle between the multicycle controller and its datapath/memory
interface mips_mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       memreq;
  logic       memwrite;
  logic       memtoreg;
  logic       alusrca;
  logic       regdst;
  logic       regwrite;
  logic       irwrite;
  logic       IorD;
  logic       pcen;
  logic       zeroext;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, memready,
    output memreq, memwrite, memtoreg, alusrca, regdst, regwrite, irwrite,
           IorD, pcen, zeroext, alusrcb, pcsrc, alucontrol, state
  );

  modport slave (
    output op, funct, zero, memready,
    input  memreq, memwrite, memtoreg, alusrca, regdst, regwrite, irwrite,
           IorD, pcen, zeroext, alusrcb, pcsrc, alucontrol, state
  );
endinterface

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS Moore control FSM with memory wait states
module mips_mc_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ENABLE_BNE    = 1'b1,
  parameter bit ENABLE_IMM    = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  mips_mc_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR  = 4'd2,  MEMRD = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6,  RTYPEWB = 4'd7,
    BEQEX   = 4'd8,  IMMEX   = 4'd9,  IMMWB   = 4'd10, JEX   = 4'd11,
    BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011, OP_SW   = 6'b101011;

  state_t     state_q, state_d;
  logic       ready, pcwrite, branch, branchn, is_imm;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Without the handshake every memory access is treated as completing at once.
  assign ready  = bus.memready | ~MEM_HANDSHAKE;
  assign is_imm = (bus.op == OP_ADDI) ||
                  (ENABLE_IMM && ((bus.op == OP_SLTI) || (bus.op == OP_ANDI) || (bus.op == OP_ORI)));

  always_comb begin
    state_d      = state_q;
    bus.memreq   = 1'b0;
    bus.memwrite = 1'b0;
    bus.memtoreg = 1'b0;
    bus.alusrca  = 1'b0;
    bus.regdst   = 1'b0;
    bus.regwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.IorD     = 1'b0;
    bus.zeroext  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    aluop        = 2'b00;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    branchn      = 1'b0;
    case (state_q)
      FETCH: begin
        bus.memreq  = 1'b1;
        bus.alusrcb = 2'b01;
        bus.irwrite = ready;
        pcwrite     = ready;
        if (ready) state_d = DECODE;
      end
      DECODE: begin
        bus.alusrcb = 2'b11;
        if ((bus.op == OP_LW) || (bus.op == OP_SW)) state_d = MEMADR;
        else if (bus.op == OP_RTYPE)                state_d = RTYPEEX;
        else if (bus.op == OP_BEQ)                  state_d = BEQEX;
        else if (ENABLE_BNE && (bus.op == OP_BNE))  state_d = BNEEX;
        else if (is_imm)                            state_d = IMMEX;
        else if (bus.op == OP_J)                    state_d = JEX;
        else                                        state_d = FETCH;
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = (bus.op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.memreq = 1'b1;
        bus.IorD   = 1'b1;
        if (ready) state_d = MEMWB;
      end
      MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        bus.memreq   = 1'b1;
        bus.memwrite = 1'b1;
        bus.IorD     = 1'b1;
        if (ready) state_d = FETCH;
      end
      RTYPEEX: begin
        bus.alusrca = 1'b1;
        aluop       = 2'b10;
        state_d     = RTYPEWB;
      end
      RTYPEWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
        state_d      = FETCH;
      end
      BEQEX, BNEEX: begin
        bus.alusrca = 1'b1;
        aluop       = 2'b01;
        bus.pcsrc   = 2'b01;
        branch      = (state_q == BEQEX);
        branchn     = (state_q == BNEEX);
        state_d     = FETCH;
      end
      IMMEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        aluop       = 2'b11;
        bus.zeroext = (bus.op == OP_ANDI) || (bus.op == OP_ORI);
        state_d     = IMMWB;
      end
      IMMWB: begin
        bus.regwrite = 1'b1;
        state_d      = FETCH;
      end
      JEX: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.pcen  = pcwrite | (branch & bus.zero) | (branchn & ~bus.zero);
  assign bus.state = state_q;

  always_comb begin
    bus.alucontrol = 3'b010;
    case (aluop)
      2'b01: bus.alucontrol = 3'b110;
      2'b10: begin
        case (bus.funct)
          6'b100010: bus.alucontrol = 3'b110;
          6'b100100: bus.alucontrol = 3'b000;
          6'b100101: bus.alucontrol = 3'b001;
          6'b101010: bus.alucontrol = 3'b111;
          default:   bus.alucontrol = 3'b010;
        endcase
      end
      2'b11: begin
        case (bus.op)
          OP_ANDI: bus.alucontrol = 3'b000;
          OP_ORI:  bus.alucontrol = 3'b001;
          OP_SLTI: bus.alucontrol = 3'b111;
          default: bus.alucontrol = 3'b010;
        endcase
      end
      default: bus.alucontrol = 3'b010;
    endcase
  end
endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - directed bench for full-feature and minimal controller configurations
module tb_mips_mc_controller;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_pass = 0;
  int   n_total = 0;

  mips_mc_controller_if a ();
  mips_mc_controller_if b ();

  mips_mc_controller #(.MEM_HANDSHAKE(1'b1), .ENABLE_BNE(1'b1), .ENABLE_IMM(1'b1))
    dut_a (.clk(clk), .reset(rst_a), .bus(a));
  mips_mc_controller #(.MEM_HANDSHAKE(1'b0), .ENABLE_BNE(1'b0), .ENABLE_IMM(1'b0))
    dut_b (.clk(clk), .reset(rst_b), .bus(b));

  always #5 clk = ~clk;

  logic [16:0] bun_a;
  assign bun_a = {a.memreq, a.memwrite, a.memtoreg, a.alusrca, a.regdst, a.regwrite,
                  a.irwrite, a.IorD, a.pcen, a.zeroext, a.alusrcb, a.pcsrc, a.alucontrol};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a.op = 6'b0; a.funct = 6'b0; a.zero = 1'b0; a.memready = 1'b0;
    b.op = 6'b0; b.funct = 6'b0; b.zero = 1'b0; b.memready = 1'b0;
    tick();
    rst_a = 1'b0;
    chk("reset_state", a.state, 0);
    chk("reset_bundle", bun_a, 17'b1000000000_01_00_010);
    tick();
    chk("fetch_stall_state", a.state, 0);
    chk("fetch_stall_irwrite", a.irwrite, 0);
    chk("fetch_stall_pcen", a.pcen, 0);

    // lw, zero wait states: 0,1,2,3,4,0
    a.op = 6'b100011; a.memready = 1'b1; #1;
    chk("lw_fetch_irwrite", a.irwrite, 1);
    chk("lw_fetch_pcen", a.pcen, 1);
    tick(); chk("lw_s1", a.state, 1); chk("lw_s1_regwrite", a.regwrite, 0);
    tick(); chk("lw_s2", a.state, 2); chk("lw_s2_alusrcb", a.alusrcb, 2'b10);
    tick(); chk("lw_s3", a.state, 3); chk("lw_s3_iord", a.IorD, 1); chk("lw_s3_regwrite", a.regwrite, 0);
    tick(); chk("lw_s4", a.state, 4); chk("lw_s4_regwrite", a.regwrite, 1); chk("lw_s4_memtoreg", a.memtoreg, 1);
    tick(); chk("lw_s0", a.state, 0); chk("lw_s0_regwrite", a.regwrite, 0); chk("lw_s0_memtoreg", a.memtoreg, 0);

    // sw with three ready-low cycles in MEMWR
    a.op = 6'b101011;
    tick(); chk("sw_s1", a.state, 1);
    tick(); chk("sw_s2", a.state, 2);
    a.memready = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      a.memready = (k == 3); #1;
      chk("sw_memwr_state", a.state, 5);
      chk("sw_memwrite", a.memwrite, 1);
      chk("sw_memreq", a.memreq, 1);
      chk("sw_regwrite", a.regwrite, 0);
      tick();
    end
    chk("sw_done_state", a.state, 0);
    chk("sw_done_memwrite", a.memwrite, 0);

    // R-type slt
    a.op = 6'b000000; a.funct = 6'b101010;
    tick(); chk("rt_s1", a.state, 1); chk("rt_dec_alusrcb", a.alusrcb, 2'b11); chk("rt_dec_aluctl", a.alucontrol, 3'b010);
    tick(); chk("rt_s6", a.state, 6); chk("rt_aluctl", a.alucontrol, 3'b111); chk("rt_alusrca", a.alusrca, 1);
    tick(); chk("rt_s7", a.state, 7); chk("rt_regdst", a.regdst, 1); chk("rt_regwrite", a.regwrite, 1);
    tick(); chk("rt_s0", a.state, 0);
    a.funct = 6'b100101; #1;
    chk("rt_fetch_aluctl", a.alucontrol, 3'b010);

    // beq
    a.op = 6'b000100; a.zero = 1'b1;
    tick(); chk("beq_s1", a.state, 1);
    tick(); chk("beq_s8", a.state, 8); chk("beq_pcen_z1", a.pcen, 1); chk("beq_pcsrc", a.pcsrc, 2'b01);
    chk("beq_aluctl", a.alucontrol, 3'b110);
    a.zero = 1'b0; #1; chk("beq_pcen_z0", a.pcen, 0);
    tick(); chk("beq_s0", a.state, 0);

    // bne
    a.op = 6'b000101; a.zero = 1'b1;
    tick(); chk("bne_s1", a.state, 1);
    tick(); chk("bne_s12", a.state, 12); chk("bne_pcen_z1", a.pcen, 0);
    a.zero = 1'b0; #1; chk("bne_pcen_z0", a.pcen, 1);
    tick(); chk("bne_s0", a.state, 0);

    // andi
    a.op = 6'b001100;
    tick(); chk("andi_s1", a.state, 1);
    tick(); chk("andi_s9", a.state, 9); chk("andi_aluctl", a.alucontrol, 3'b000); chk("andi_zeroext", a.zeroext, 1);
    tick(); chk("andi_s10", a.state, 10); chk("andi_regwrite", a.regwrite, 1); chk("andi_regdst", a.regdst, 0);
    tick(); chk("andi_s0", a.state, 0);

    // ori and slti in IMMEX
    a.op = 6'b001101;
    tick(); tick(); chk("ori_s9", a.state, 9); chk("ori_aluctl", a.alucontrol, 3'b001); chk("ori_zeroext", a.zeroext, 1);
    tick(); tick(); chk("ori_s0", a.state, 0);
    a.op = 6'b001010;
    tick(); tick(); chk("slti_s9", a.state, 9); chk("slti_aluctl", a.alucontrol, 3'b111); chk("slti_zeroext", a.zeroext, 0);
    tick(); tick(); chk("slti_s0", a.state, 0);

    // j
    a.op = 6'b000010;
    tick(); chk("j_s1", a.state, 1);
    tick(); chk("j_s11", a.state, 11); chk("j_pcen", a.pcen, 1); chk("j_pcsrc", a.pcsrc, 2'b10);
    tick(); chk("j_s0", a.state, 0);

    // undecoded opcode
    a.op = 6'b111111;
    tick(); chk("nop_s1", a.state, 1);
    tick(); chk("nop_s0", a.state, 0);

    // reset while stalled in MEMRD
    a.op = 6'b100011;
    tick(); tick(); chk("rst_rd_s2", a.state, 2);
    a.memready = 1'b0;
    tick(); chk("rst_rd_s3", a.state, 3); chk("rst_rd_regwrite", a.regwrite, 0); chk("rst_rd_pcen", a.pcen, 0);
    tick(); chk("rst_rd_stall", a.state, 3);
    rst_a = 1'b1;
    tick(); rst_a = 1'b0; chk("rst_rd_s0", a.state, 0);

    // reset while stalled in MEMWR drops memwrite
    a.op = 6'b101011; a.memready = 1'b1;
    tick(); tick();
    a.memready = 1'b0;
    tick(); chk("rst_wr_s5", a.state, 5); chk("rst_wr_memwrite", a.memwrite, 1);
    rst_a = 1'b1;
    tick(); rst_a = 1'b0;
    chk("rst_wr_s0", a.state, 0); chk("rst_wr_memwrite_drop", a.memwrite, 0);

    // minimal configuration: no handshake, no bne, addi only
    rst_b = 1'b1; b.memready = 1'b0; b.op = 6'b100011;
    tick(); rst_b = 1'b0;
    chk("b_reset_state", b.state, 0);
    chk("b_fetch_irwrite", b.irwrite, 1);
    tick(); chk("b_lw_s1", b.state, 1);
    tick(); chk("b_lw_s2", b.state, 2);
    tick(); chk("b_lw_s3", b.state, 3);
    tick(); chk("b_lw_s4", b.state, 4); chk("b_lw_regwrite", b.regwrite, 1);
    tick(); chk("b_lw_s0", b.state, 0);
    b.op = 6'b000101;
    tick(); chk("b_bne_s1", b.state, 1);
    tick(); chk("b_bne_s0", b.state, 0);
    b.op = 6'b001100;
    tick(); chk("b_andi_s1", b.state, 1); chk("b_andi_regwrite1", b.regwrite, 0);
    tick(); chk("b_andi_s0", b.state, 0); chk("b_andi_regwrite0", b.regwrite, 0);
    b.op = 6'b001000;
    tick(); chk("b_addi_s1", b.state, 1);
    tick(); chk("b_addi_s9", b.state, 9); chk("b_addi_aluctl", b.alucontrol, 3'b010);
    tick(); chk("b_addi_s10", b.state, 10);
    tick(); chk("b_addi_s0", b.state, 0);
    b.op = 6'b101011;
    tick(); tick();
    tick(); chk("b_sw_s5", b.state, 5); chk("b_sw_memwrite", b.memwrite, 1);
    tick(); chk("b_sw_s0", b.state, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle MIPS control unit with a memory wait-state handshake and parameter-selected instruction extensions. It drives the same control bundle the multicycle datapath consumes (mux selects, register/IR/PC enables, ALU control) from `op`, `funct` and `zero`. Unlike the fixed-latency controller, it stalls in any memory state until `memready` is asserted. It also optionally decodes `bne` and the immediate ALU group (`addi`/`andi`/`ori`/`slti`). It sits inside `mips` in place of the fixed controller, between instruction register and datapath.

## Interface
- `MEM_HANDSHAKE`, 1, 1: memory states wait for `memready`; 0: `memready` ignored, every memory access takes exactly one cycle.
- `ENABLE_BNE`, 1, decode op 000101.
- `ENABLE_IMM`, 1, decode `addi` 001000, `slti` 001010, `andi` 001100 and `ori` 001101. When 0, only `addi` is decoded.

- `clk` in 1: single clock, all state on its rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: instr[31:26].
- `funct` in 6: instr[5:0].
- `zero` in 1: ALU zero flag.
- `memready` in 1: memory completes the current access this cycle.
- `memreq` out 1: memory access active.
- `memwrite` out 1: write strobe.
- `memtoreg`, `alusrca`, `regdst`, `regwrite`, `irwrite`, `IorD`, `pcen`, `zeroext` out 1 each: datapath controls.
- `alusrcb` out 2: ALU B source select (00 reg, 01 const 4, 10 imm, 11 imm<<2).
- `pcsrc` out 2: PC source select (00 ALU result, 01 ALUOut, 10 jump target).
- `alucontrol` out 3: ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt).
- `state` out 4: current state encoding, for debug.

## Operation
- Moore FSM, state encodings 0–12: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, IMMEX, IMMWB, JEX, BNEEX.
- Every output defaults to 0 unless a state asserts it. The internal aluop defaults to 00.
- FETCH:
  - Outputs: `memreq`=1, `IorD`=0, `alusrca`=0, `alusrcb`=01, aluop 00, `pcsrc`=00.
  - `irwrite` and pcwrite are asserted only when ready, where ready = `memready` OR NOT `MEM_HANDSHAKE`.
  - Transition: DECODE when ready, else stay in FETCH.
- DECODE:
  - Outputs: `alusrcb`=11, aluop 00.
  - Transitions by `op`:
    - lw/sw (100011/101011) go to MEMADR.
    - R-type (000000) goes to RTYPEEX.
    - beq (000100) goes to BEQEX.
    - bne goes to BNEEX if enabled.
    - An enabled immediate op goes to IMMEX.
    - j (000010) goes to JEX.
    - Any other opcode goes to FETCH, i.e. it executes as a NOP.
- MEMADR: `alusrca`=1, `alusrcb`=10. Transition: MEMRD for lw, MEMWR for sw.
- MEMRD: `memreq`=1, `IorD`=1. Transition: MEMWB when ready, else stay.
- MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0. Transition: FETCH.
- MEMWR: `memreq`=1, `memwrite`=1, `IorD`=1. Both strobes are held every cycle until ready. Transition: FETCH when ready.
- RTYPEEX: `alusrca`=1, `alusrcb`=00, aluop 10. Transition: RTYPEWB.
- RTYPEWB: `regwrite`=1, `regdst`=1. Transition: FETCH.
- BEQEX / BNEEX:
  - Outputs: `alusrca`=1, `alusrcb`=00, aluop 01, `pcsrc`=01.
  - Qualifier: branch in BEQEX, branchn in BNEEX.
  - Transition: FETCH.
- IMMEX:
  - Outputs: `alusrca`=1, `alusrcb`=10, aluop 11.
  - `zeroext`=1 for andi/ori.
  - Transition: IMMWB.
- IMMWB: `regwrite`=1, `regdst`=0, `memtoreg`=0. Transition: FETCH.
- JEX: `pcsrc`=10, pcwrite=1. Transition: FETCH.
- `pcen` = pcwrite OR (branch AND `zero`) OR (branchn AND NOT `zero`).
- ALU decode for `alucontrol`:
  - aluop 00 gives 010; aluop 01 gives 110.
  - aluop 10 decodes by `funct`: 100000 gives 010, 100010 gives 110, 100100 gives 000, 100101 gives 001, 101010 gives 111. Any other funct gives 010.
  - aluop 11 decodes by `op`: addi gives 010, andi gives 000, ori gives 001, slti gives 111.

## Timing
- `state` is registered; all outputs are combinational from `state`, plus `memready`, `op`, `funct` and `zero` where listed above.
- `reset` high at a rising edge puts `state` into FETCH. This takes effect from any state, including mid-stall in MEMRD or MEMWR.
  - An aborted write drops `memwrite` in the cycle after the reset edge.
- In FETCH after reset, outputs are `memreq`=1, `alusrcb`=01, `alucontrol`=010. All other outputs are 0.
- Zero-wait-state latencies in cycles:
  - lw 5; sw 4; R-type 4; imm 4; beq/bne 3; j 3; undecoded opcode 2.
- Each ready-low cycle in FETCH, MEMRD or MEMWR adds 1 cycle.
- While stalled, `irwrite`, `pcen` and `regwrite` are all 0.
- `op` and `funct` are sampled during DECODE and the execute states. They must hold stable; the instruction register guarantees this because `irwrite` only fires in FETCH.

## Test plan
- Reset, then `memready`=1 and `op`=100011 (lw) → state sequence 0,1,2,3,4,0. `regwrite`=1 and `memtoreg`=1 only in state 4.
- sw with `memready` low for 3 cycles in MEMWR → `memwrite`=1 for 4 consecutive cycles. Then FETCH, with `regwrite` never asserted.
- R-type with `funct`=101010 → `alucontrol`=111 in RTYPEEX; `regdst`=1 and `regwrite`=1 in RTYPEWB.
- Branch `pcen` checks:
  - beq with `zero`=1 → `pcen`=1 and `pcsrc`=01 in BEQEX.
  - bne with `zero`=1 → `pcen`=0.
  - With `ENABLE_BNE`=0, op 000101 goes DECODE → FETCH.
- andi (001100) → `alucontrol`=000 and `zeroext`=1 in IMMEX.
  - With `ENABLE_IMM`=0, the same op is treated as a NOP: 2-cycle latency, no `regwrite`.
- Reset asserted in MEMRD while stalled → state=0 after the next edge. With `MEM_HANDSHAKE`=0 and `memready` held at 0, lw still completes in 5 cycles.
